branch_pc_sequencer: RTL and testbench

- Program-counter update stage that sits directly downstream of the conditional-branch flag flip-flop.
- Owns the PC register and performs all PC updates:
  - sequential fetch increment;
  - conditional branch, resolved by the registered branch flag (con_out) and its valid strobe;
  - jump-register;
  - jump-and-link.
- Talks to the control unit with a start/done handshake, so PC update and flag evaluation happen in distinct, checkable cycles.

---
 rtl/branch_pc_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_branch_pc_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_pc_sequencer.sv
// Program-counter update stage. It owns the PC register and performs four
// kinds of update: sequential increment, conditional branch (resolved by the
// registered condition flag), jump-register, and jump-and-link.
// It talks to the control unit through a start/done handshake.
// Optional build macro: BRANCH_STATS_EN adds two saturating branch counters
// (stat_taken / stat_not_taken).
module branch_pc_sequencer #(
   parameter int unsigned     PC_W     = 32,
   parameter int unsigned     OFF_W    = 19,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            clear_n,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [31:0]     ir,
   input  logic [PC_W-1:0] rs_val,
   input  logic            con_out,
   input  logic            con_valid,
   output logic [PC_W-1:0] pc,
   output logic [PC_W-1:0] link_val,
   output logic            link_we,
   output logic            taken,
   output logic            busy,
   output logic            done
`ifdef BRANCH_STATS_EN
  ,output logic [15:0]     stat_taken,
   output logic [15:0]     stat_not_taken
`endif
);

   typedef enum logic [1:0] {OP_INC, OP_BR, OP_JR, OP_JAL} op_e;
   typedef enum logic [1:0] {S_IDLE, S_WAIT_CON, S_UPDATE, S_DONE} state_e;

   state_e            state_q, state_d;
   op_e               op_q, op_d;
   logic [OFF_W-1:0]  off_q, off_d;
   logic [PC_W-1:0]   rs_q, rs_d;
   logic              take_q, take_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [PC_W-1:0]   link_val_q, link_val_d;
   logic              link_we_q, link_we_d;
   logic              taken_q, taken_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;
   logic [PC_W-1:0]   pc_inc;
   logic [PC_W-1:0]   off_ext;

   // Instruction bits above the offset field are not used by this stage.
   logic unused_ir_bits;
   assign unused_ir_bits = ^ir[31:OFF_W];

`ifdef BRANCH_STATS_EN
   logic [15:0] stat_taken_q, stat_taken_d;
   logic [15:0] stat_not_taken_q, stat_not_taken_d;
`endif

   // Address arithmetic wraps silently modulo 2^PC_W.
   assign pc_inc  = pc_q + PC_W'(1);
   assign off_ext = {{(PC_W-OFF_W){off_q[OFF_W-1]}}, off_q};

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of all others.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic: branches wait for the condition flag, others go straight to UPDATE.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:     if (start) state_d = (op == OP_BR) ? S_WAIT_CON : S_UPDATE;
         S_WAIT_CON: if (con_valid) state_d = S_UPDATE;
         S_UPDATE:   state_d = S_DONE;
         S_DONE:     state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // Output and datapath next-values; strobes are recomputed every cycle.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      op_d       = op_q;
      off_d      = off_q;
      rs_d       = rs_q;
      take_d     = take_q;
      pc_d       = pc_q;
      link_val_d = link_val_q;
      link_we_d  = 1'b0;
      taken_d    = 1'b0;
      done_d     = 1'b0;
      // busy lingers one cycle past DONE so the controller sees it fall after done.
      busy_d     = (state_d != S_IDLE) || (state_q == S_DONE);
`ifdef BRANCH_STATS_EN
      stat_taken_d     = stat_taken_q;
      stat_not_taken_d = stat_not_taken_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d   = op_e'(op);
               off_d  = ir[OFF_W-1:0];
               rs_d   = rs_val;
               take_d = 1'b0;
            end
         end
         S_WAIT_CON: begin
            if (con_valid) take_d = con_out;
         end
         S_UPDATE: begin
            // done/taken/link_we are registered here so they appear with the DONE state.
            done_d = 1'b1;
            unique case (op_q)
               OP_INC: pc_d = pc_inc;
               OP_BR: begin
                  pc_d    = take_q ? (pc_inc + off_ext) : pc_inc;
                  taken_d = take_q;
               end
               OP_JR: begin
                  pc_d    = rs_q;
                  taken_d = 1'b1;
               end
               OP_JAL: begin
                  link_val_d = pc_inc;
                  link_we_d  = 1'b1;
                  pc_d       = rs_q;
                  taken_d    = 1'b1;
               end
               default: pc_d = pc_q;
            endcase
         end
         S_DONE: begin
`ifdef BRANCH_STATS_EN
            if (op_q == OP_BR) begin
               if (take_q) begin
                  if (stat_taken_q != 16'hFFFF) stat_taken_d = stat_taken_q + 16'd1;
               end else begin
                  if (stat_not_taken_q != 16'hFFFF) stat_not_taken_d = stat_not_taken_q + 16'd1;
               end
            end
`endif
         end
         default: ;
      endcase
   end

   // Datapath and output registers; reset abandons any operation in flight.
   // NOTE: every register here is a plain flop (no memory array), so all of
   // them take the asynchronous reset.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         op_q       <= OP_INC;
         off_q      <= '0;
         rs_q       <= '0;
         take_q     <= 1'b0;
         pc_q       <= RESET_PC;
         link_val_q <= '0;
         link_we_q  <= 1'b0;
         taken_q    <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         op_q       <= op_d;
         off_q      <= off_d;
         rs_q       <= rs_d;
         take_q     <= take_d;
         pc_q       <= pc_d;
         link_val_q <= link_val_d;
         link_we_q  <= link_we_d;
         taken_q    <= taken_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
      end
   end

`ifdef BRANCH_STATS_EN
   // Saturating branch statistics, cleared only by reset.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         stat_taken_q     <= '0;
         stat_not_taken_q <= '0;
      end else begin
         stat_taken_q     <= stat_taken_d;
         stat_not_taken_q <= stat_not_taken_d;
      end
   end

   assign stat_taken     = stat_taken_q;
   assign stat_not_taken = stat_not_taken_q;
`endif

   assign pc       = pc_q;
   assign link_val = link_val_q;
   assign link_we  = link_we_q;
   assign taken    = taken_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_branch_pc_sequencer.sv
// Self-checking bench for branch_pc_sequencer: a chained table of operations
// with hand-computed PC/flag/latency expectations, followed by hand-written
// sequences for start-while-busy and reset in the middle of a branch.
module tb_branch_pc_sequencer;

   logic        clk = 1'b0;
   logic        clear_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] ir;
   logic [31:0] rs_val;
   logic        con_out;
   logic        con_valid;
   logic [31:0] pc;
   logic [31:0] link_val;
   logic        link_we;
   logic        taken;
   logic        busy;
   logic        done;
`ifdef BRANCH_STATS_EN
   logic [15:0] stat_taken;
   logic [15:0] stat_not_taken;
`endif

   int checks = 0;
   int errors = 0;

   branch_pc_sequencer dut (
      .clk(clk), .clear_n(clear_n), .start(start), .op(op), .ir(ir),
      .rs_val(rs_val), .con_out(con_out), .con_valid(con_valid),
      .pc(pc), .link_val(link_val), .link_we(link_we), .taken(taken),
      .busy(busy), .done(done)
`ifdef BRANCH_STATS_EN
     ,.stat_taken(stat_taken), .stat_not_taken(stat_not_taken)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // delay = number of WAIT_CON cycles with con_valid low before it rises.
   // lat counts cycles from the start cycle (as 1) to the done cycle inclusive.
   typedef struct {
      logic [1:0]  op;
      logic [31:0] ir;
      logic [31:0] rs;
      int          delay;
      logic        con;
      logic [31:0] exp_pc;
      logic        exp_taken;
      logic        exp_lwe;
      logic [31:0] exp_lval;
      int          exp_lat;
   } vec_t;

   vec_t vecs[13];

   // Issue one operation and observe its completion.
   task automatic run_op(input vec_t v, output logic seen, output int lat,
                         output int busy_cnt, output logic tk, output logic lwe,
                         output logic [31:0] lval, output logic [31:0] pc_at_done,
                         output logic one_cycle);
      int n;
      @(negedge clk);
      start = 1'b1; op = v.op; ir = v.ir; rs_val = v.rs; con_valid = 1'b0;
      @(posedge clk);
      n = 0; seen = 1'b0; busy_cnt = 0; lat = 0;
      tk = 1'b0; lwe = 1'b0; lval = '0; pc_at_done = '0; one_cycle = 1'b0;
      while (!seen && n < 60) begin
         @(negedge clk);
         start     = 1'b0;
         con_valid = (v.op == 2'b01) && (n == v.delay);
         con_out   = con_valid ? v.con : ~v.con;
         if (busy) busy_cnt++;
         if (done) begin
            seen = 1'b1; lat = n + 2;
            tk = taken; lwe = link_we; lval = link_val; pc_at_done = pc;
         end else begin
            @(posedge clk);
            n++;
         end
      end
      con_valid = 1'b0;
      if (seen) begin
         @(negedge clk);
         one_cycle = !done && !link_we;
         n = 0;
         while (busy && n < 10) begin
            busy_cnt++;
            @(negedge clk);
            n++;
         end
      end
   endtask

   initial begin
      logic        seen, tk, lwe, one_cycle;
      int          lat, bcnt, dcnt;
      logic [31:0] lval, pcd;

      // op, ir, rs, delay, con, exp_pc, exp_taken, exp_lwe, exp_lval, exp_lat
      vecs[0]  = '{2'b00, 32'h0,        32'h0,        0, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 32'h0,         3};
      vecs[1]  = '{2'b10, 32'h0,        32'h20,       0, 1'b0, 32'h0000_0020, 1'b1, 1'b0, 32'h0,         3};
      vecs[2]  = '{2'b01, 32'h7FFFC,    32'h0,        1, 1'b1, 32'h0000_001D, 1'b1, 1'b0, 32'h0,         5};
      vecs[3]  = '{2'b10, 32'h0,        32'h20,       0, 1'b0, 32'h0000_0020, 1'b1, 1'b0, 32'h0,         3};
      vecs[4]  = '{2'b01, 32'h8,        32'h0,        0, 1'b0, 32'h0000_0021, 1'b0, 1'b0, 32'h0,         4};
      vecs[5]  = '{2'b10, 32'h0,        32'h40,       0, 1'b0, 32'h0000_0040, 1'b1, 1'b0, 32'h0,         3};
      vecs[6]  = '{2'b11, 32'h0,        32'h100,      0, 1'b0, 32'h0000_0100, 1'b1, 1'b1, 32'h41,        3};
      vecs[7]  = '{2'b01, 32'h8,        32'h0,        2, 1'b1, 32'h0000_0109, 1'b1, 1'b0, 32'h41,        6};
      vecs[8]  = '{2'b01, 32'hFFF8_0005, 32'h0,       0, 1'b1, 32'h0000_010F, 1'b1, 1'b0, 32'h41,        4};
      vecs[9]  = '{2'b10, 32'h0,        32'hFFFF_FFFF, 0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h41,       3};
      vecs[10] = '{2'b00, 32'h0,        32'h0,        0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h41,        3};
      vecs[11] = '{2'b01, 32'h40000,    32'h0,        0, 1'b1, 32'hFFFC_0001, 1'b1, 1'b0, 32'h41,        4};
      vecs[12] = '{2'b11, 32'h0,        32'h5,        0, 1'b0, 32'h0000_0005, 1'b1, 1'b1, 32'hFFFC_0002, 3};

      clear_n = 1'b0; start = 1'b0; op = 2'b00; ir = '0; rs_val = '0;
      con_out = 1'b0; con_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("reset pc", pc, 32'h0);
      check("reset busy", {31'b0, busy}, 32'h0);
      check("reset done", {31'b0, done}, 32'h0);
      check("reset taken", {31'b0, taken}, 32'h0);
      check("reset link_we", {31'b0, link_we}, 32'h0);
      check("reset link_val", link_val, 32'h0);
      clear_n = 1'b1;

      for (int i = 0; i < 13; i++) begin
         run_op(vecs[i], seen, lat, bcnt, tk, lwe, lval, pcd, one_cycle);
         check($sformatf("v%0d done seen", i), {31'b0, seen}, 32'h1);
         if (seen) begin
            check($sformatf("v%0d pc", i), pcd, vecs[i].exp_pc);
            check($sformatf("v%0d taken", i), {31'b0, tk}, {31'b0, vecs[i].exp_taken});
            check($sformatf("v%0d link_we", i), {31'b0, lwe}, {31'b0, vecs[i].exp_lwe});
            check($sformatf("v%0d link_val", i), lval, vecs[i].exp_lval);
            check($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d busy cycles", i), bcnt, vecs[i].exp_lat);
            check($sformatf("v%0d single-cycle strobes", i), {31'b0, one_cycle}, 32'h1);
         end
      end

`ifdef BRANCH_STATS_EN
      check("stat_taken", {16'b0, stat_taken}, 32'd4);
      check("stat_not_taken", {16'b0, stat_not_taken}, 32'd1);
`endif

      // start held through UPDATE and DONE must not launch a second operation.
      @(negedge clk);
      start = 1'b1; op = 2'b00; rs_val = 32'h0;
      @(posedge clk);
      dcnt = 0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (n < 2) begin
            start = 1'b1; op = 2'b10; rs_val = 32'hDEAD;
         end else begin
            start = 1'b0;
         end
         if (done) dcnt++;
      end
      check("ignored start done count", dcnt, 1);
      check("ignored start pc", pc, 32'h6);
      check("ignored start busy", {31'b0, busy}, 32'h0);

      // Reset while waiting for the condition flag.
      @(negedge clk);
      start = 1'b1; op = 2'b01; ir = 32'h8;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; con_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("wait_con pc held", pc, 32'h6);
      check("wait_con busy", {31'b0, busy}, 32'h1);
      clear_n = 1'b0;
      #1;
      check("mid reset pc", pc, 32'h0);
      check("mid reset busy", {31'b0, busy}, 32'h0);
      @(negedge clk);
      clear_n = 1'b1; con_valid = 1'b1; con_out = 1'b1;
      dcnt = 0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (n == 2) con_valid = 1'b0;
         if (done) dcnt++;
      end
      check("post reset done count", dcnt, 0);
      check("post reset pc", pc, 32'h0);
      check("post reset busy", {31'b0, busy}, 32'h0);
`ifdef BRANCH_STATS_EN
      check("post reset stat_taken", {16'b0, stat_taken}, 32'd0);
      check("post reset stat_not_taken", {16'b0, stat_not_taken}, 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
